// File: rtl/sdr_decoder_mx.sv
// Multi-lane bit-serial signed-digit decoder: rebuilds one two's-complement word
// per lane from MSB-first digits and hands it downstream through a one-entry buffer.
module sdr_decoder_mx #(
  parameter int LANES  = 8,
  parameter int DIGITS = 8,
  parameter int OUT_W  = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_start,
  input  logic                   budget,
  input  logic [LANES-1:0]       digit_stream,
  input  logic [LANES-1:0]       sign_stream,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       budget_err,
  output logic [LANES-1:0]       fmt_err,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(DIGITS);
  localparam int NZ_W  = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bud_q, bud_d;
  logic                    take, complete, frame_set, restart;

  logic signed [OUT_W-1:0] acc_q [LANES];
  logic signed [OUT_W-1:0] acc_d [LANES];
  logic [NZ_W-1:0]         nz_q  [LANES];
  logic [NZ_W-1:0]         nz_d  [LANES];
  logic [LANES-1:0]        fmt_q, fmt_d, over_d;

  assign restart = in_valid & in_start;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bud_d     = bud_q;
    take      = 1'b0;
    complete  = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (restart) begin
          take    = 1'b1;
          cnt_d   = CNT_W'(1);
          bud_d   = budget;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          take = 1'b1;
          if (in_start) begin
            frame_set = 1'b1;
            cnt_d     = CNT_W'(1);
            bud_d     = budget;
          end else if (cnt_q == LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-lane datapath; a start digit begins from a zero base so the same
  // 2*acc + d step serves both the first digit and every later one.
  always_comb begin
    logic signed [OUT_W-1:0] dv;
    logic signed [OUT_W-1:0] base;
    dv     = '0;
    base   = '0;
    fmt_d  = '0;
    over_d = '0;
    for (int i = 0; i < LANES; i++) begin
      dv       = digit_stream[i] ? (sign_stream[i] ? '1 : OUT_W'(1)) : '0;
      base     = restart ? '0 : acc_q[i];
      acc_d[i] = (base <<< 1) + dv;
      nz_d[i]  = (restart ? '0 : nz_q[i]) + NZ_W'(digit_stream[i]);
      fmt_d[i] = (~restart & fmt_q[i]) | (sign_stream[i] & ~digit_stream[i]);
      over_d[i] = nz_d[i] > (bud_q ? NZ_W'(3) : NZ_W'(2));
    end
  end

  // NOTE: the accumulator array is a handful of flops, not a RAM, so it is
  // reset explicitly; a mid-word reset must leave no trace of the partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bud_q   <= 1'b0;
      fmt_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
        nz_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bud_q   <= bud_d;
      if (take) begin
        fmt_q <= fmt_d;
        for (int i = 0; i < LANES; i++) begin
          acc_q[i] <= acc_d[i];
          nz_q[i]  <= nz_d[i];
        end
      end
    end
  end

  // One-entry output buffer: a completed word loads only if the slot is free
  // or is being drained this same cycle; otherwise it is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      budget_err <= '0;
      fmt_err    <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (frame_set) frame_err <= 1'b1;
      if (complete && (!out_valid || out_ready)) begin
        out_valid  <= 1'b1;
        budget_err <= over_d;
        fmt_err    <= fmt_d;
        for (int i = 0; i < LANES; i++) out_data[i*OUT_W +: OUT_W] <= acc_d[i];
      end else if (complete) begin
        overflow <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdr_decoder_mx.sv
// Directed self-checking bench for sdr_decoder_mx with hand-computed expectations.
module tb_sdr_decoder_mx;

  localparam int LANES  = 8;
  localparam int DIGITS = 8;
  localparam int OUT_W  = 9;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid, in_start, budget;
  logic [LANES-1:0]       digit_stream, sign_stream;
  logic                   out_valid, out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       budget_err, fmt_err;
  logic                   frame_err, overflow;

  sdr_decoder_mx #(.LANES(LANES), .DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start),
    .budget(budget), .digit_stream(digit_stream), .sign_stream(sign_stream),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .budget_err(budget_err), .fmt_err(fmt_err), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int acc_mark;
  logic ready_on_last = 1'b0;

  logic [DIGITS-1:0] dig [LANES];
  logic [DIGITS-1:0] sgn [LANES];

  always @(posedge clk) if (out_valid && out_ready) n_acc++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] lane(input int i);
    return out_data[i*OUT_W +: OUT_W];
  endfunction

  task automatic clear_pattern();
    for (int i = 0; i < LANES; i++) begin
      dig[i] = '0;
      sgn[i] = '0;
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0; in_start = 1'b0; digit_stream = '0; sign_stream = '0;
    @(posedge clk); #1;
  endtask

  // Budget toggles after the start digit so a design that fails to latch it shows up.
  task automatic drive_digit(input int k, input logic start, input logic bud);
    in_valid = 1'b1;
    in_start = start;
    budget   = start ? bud : ~bud;
    for (int i = 0; i < LANES; i++) begin
      digit_stream[i] = dig[i][DIGITS-1-k];
      sign_stream[i]  = sgn[i][DIGITS-1-k];
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic bud, input int stall_at, input int stall_len);
    for (int k = 0; k < DIGITS; k++) begin
      if (k == stall_at) begin
        in_valid = 1'b0; in_start = 1'b0;
        repeat (stall_len) begin @(posedge clk); #1; end
      end
      if (k == DIGITS - 1 && ready_on_last) out_ready = 1'b1;
      drive_digit(k, k == 0, bud);
    end
    in_valid = 1'b0; in_start = 1'b0; digit_stream = '0; sign_stream = '0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_start = 1'b0; budget = 1'b0;
    digit_stream = '0; sign_stream = '0; out_ready = 1'b1;
    clear_pattern();
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_flags", {budget_err, fmt_err, frame_err, overflow}, 0);
    #4 reset = 1'b1;
    @(posedge clk); #1;

    // Single word: lane0 = 8-1 = +7, lane1 = -4+1 = -3
    clear_pattern();
    dig[0] = 8'b00001001; sgn[0] = 8'b00000001;
    dig[1] = 8'b00000101; sgn[1] = 8'b00000100;
    send_word(1'b0, -1, 0);
    check("t1_valid", out_valid, 1);
    check("t1_lane0", lane(0), 9'h007);
    check("t1_lane1", lane(1), 9'h1FD);
    check("t1_lane2", lane(2), 9'h000);
    check("t1_berr", budget_err, 8'h00);
    check("t1_ferr", fmt_err, 8'h00);
    check("t1_sticky", {frame_err, overflow}, 2'b00);
    @(posedge clk); #1;
    check("t1_drain", out_valid, 0);
    check("t1_keep", lane(0), 9'h007);

    // Budget: 4 nonzero vs limit 3, 3 nonzero vs limit 3, 3 nonzero vs limit 2
    clear_pattern();
    dig[2] = 8'b10101010;
    send_word(1'b1, -1, 0);
    check("t2a_lane2", lane(2), 9'h0AA);
    check("t2a_berr", budget_err, 8'h04);
    @(posedge clk); #1;
    dig[2] = 8'b10101000;
    send_word(1'b1, -1, 0);
    check("t2b_lane2", lane(2), 9'h0A8);
    check("t2b_berr", budget_err, 8'h00);
    @(posedge clk); #1;
    send_word(1'b0, -1, 0);
    check("t2c_berr", budget_err, 8'h04);
    @(posedge clk); #1;

    // Format error on digit 4 of lane3 plus a 5-cycle stall after digit 5
    clear_pattern();
    dig[3] = 8'b00000011; sgn[3] = 8'b00010000;
    send_word(1'b0, 5, 5);
    check("t3_valid", out_valid, 1);
    check("t3_lane3", lane(3), 9'h003);
    check("t3_ferr", fmt_err, 8'h08);
    check("t3_berr", budget_err, 8'h00);
    @(posedge clk); #1;
    check("t3_drain", out_valid, 0);

    // Abort: four digits of a word, then a fresh all +1 word starts on digit 5
    acc_mark = n_acc;
    for (int i = 0; i < LANES; i++) begin dig[i] = '1; sgn[i] = '1; end
    for (int k = 0; k < 4; k++) drive_digit(k, k == 0, 1'b0);
    check("t4_no_frame_yet", frame_err, 0);
    for (int i = 0; i < LANES; i++) sgn[i] = '0;
    send_word(1'b0, -1, 0);
    check("t4_frame", frame_err, 1);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, {8{9'h0FF}});
    check("t4_berr", budget_err, 8'hFF);
    @(posedge clk); #1;
    check("t4_single", n_acc - acc_mark, 1);
    check("t4_drain", out_valid, 0);

    // Backpressure: A held, B dropped, C loaded on the same cycle A drains
    out_ready = 1'b0;
    clear_pattern();
    dig[0] = 8'b00000001;
    send_word(1'b0, -1, 0);
    check("t5_a_valid", out_valid, 1);
    check("t5_a_data", out_data, 72'd1);
    clear_pattern();
    dig[0] = 8'b00000010;
    dig[1] = 8'b00000000; sgn[1] = 8'b00000001;
    dig[2] = 8'b10101000;
    send_word(1'b0, -1, 0);
    check("t5_hold_valid", out_valid, 1);
    check("t5_hold_data", out_data, 72'd1);
    check("t5_hold_flags", {budget_err, fmt_err}, 16'h0000);
    check("t5_overflow", overflow, 1);
    acc_mark = n_acc;
    clear_pattern();
    dig[0] = 8'b00000101;
    ready_on_last = 1'b1;
    send_word(1'b0, -1, 0);
    ready_on_last = 1'b0;
    check("t5_c_valid", out_valid, 1);
    check("t5_c_data", out_data, 72'd5);
    check("t5_a_taken", n_acc - acc_mark, 1);
    @(posedge clk); #1;
    check("t5_drain", out_valid, 0);

    // Async reset between edges in the middle of a word
    clear_pattern();
    for (int i = 0; i < LANES; i++) dig[i] = '1;
    for (int k = 0; k < 3; k++) drive_digit(k, k == 0, 1'b0);
    #3 reset = 1'b0;
    #1;
    check("t6_rst_data", out_data, 0);
    check("t6_rst_flags", {out_valid, budget_err, fmt_err, frame_err, overflow}, 0);
    #2 reset = 1'b1;
    idle_cycle();
    idle_cycle();
    check("t6_no_partial", out_valid, 0);
    clear_pattern();
    dig[0] = 8'b00001001; sgn[0] = 8'b00000001;
    dig[1] = 8'b00000101; sgn[1] = 8'b00000100;
    send_word(1'b0, -1, 0);
    check("t6_valid", out_valid, 1);
    check("t6_lane0", lane(0), 9'h007);
    check("t6_lane1", lane(1), 9'h1FD);
    check("t6_sticky", {frame_err, overflow}, 2'b00);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdr_decoder_mx.md
Name: sdr_decoder_mx

Overview:
- Bit-serial signed-digit (SDR) decoder: the receive end of the 8-lane SDR encoder array.
- Each lane gets one digit per cycle, MSB first, as a pair: magnitude bit in `digit_stream` and sign bit in `sign_stream`. Each lane rebuilds a signed two's-complement word.
- Per-lane budget and format checks run alongside. Completed 8-lane words go to the downstream MAC/accumulator through a one-entry valid/ready output buffer.

Parameters:
- LANES, 8, number of parallel serial lanes.
- DIGITS, 8, signed digits per word (weights 2^(DIGITS-1) down to 2^0).
- OUT_W, 9, signed output width per lane; must be at least DIGITS+1 to hold the range ±(2^DIGITS-1).

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: a digit is present on all lanes this cycle.
- `in_start` input 1: qualified by `in_valid`; marks the first (MSB) digit of a word.
- `budget` input 1: 0 means a limit of 2 nonzero digits per lane; 1 means 3. Sampled on the start digit.
- `digit_stream` input LANES: per-lane digit magnitude (1 means a nonzero digit).
- `sign_stream` input LANES: per-lane digit sign (1 means -1); only meaningful when the matching `digit_stream` bit is 1.
- `out_valid` output 1: `out_data` holds a complete word.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output LANES*OUT_W: lane i occupies bits [i*OUT_W +: OUT_W], signed.
- `budget_err` output LANES: per-lane flag, travels with `out_data`.
- `fmt_err` output LANES: per-lane flag, travels with `out_data`.
- `frame_err` output 1: sticky; set when a word is aborted by an early `in_start`.
- `overflow` output 1: sticky; set when a completed word is dropped.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE; accumulators and digit counter go to 0.
  - `out_valid`=0, `out_data`=0, `budget_err`=0, `fmt_err`=0, `frame_err`=0, `overflow`=0.
  - A reset in the middle of a word discards the partial word; no output is produced for it.
- Digit value per lane: d = 0 if `digit_stream`=0; otherwise d = -1 if `sign_stream`=1, else +1.
- Format error: `sign_stream`=1 with `digit_stream`=0 is decoded as d=0 and sets that lane's `fmt_err` for the current word.
- FSM state IDLE:
  - `in_valid` & `in_start`: acc = d, nz = |d|, cnt = 1, latch `budget`, go to ACCUM.
  - `in_valid` without `in_start`: digit ignored, no flag.
- FSM state ACCUM:
  - `in_valid`=0: hold all state (stall); no cycle limit.
  - `in_valid` & !`in_start`: acc = 2*acc + d (signed, OUT_W bits, cannot overflow); nz += |d|; cnt++.
  - When the digit taken is number DIGITS (cnt==DIGITS-1 before the update): the word completes and the FSM goes to IDLE.
  - `in_valid` & `in_start`: the partial word is discarded, `frame_err` is set, and the new word restarts exactly as from IDLE.
- Word completion:
  - `budget_err[i]` = nz_i > (latched budget ? 3 : 2).
  - `fmt_err[i]` = any format error seen on lane i during the word.
- A new word may start on the cycle immediately after the last digit; full back-to-back throughput is 1 word per DIGITS cycles.
- Output buffer (one entry):
  - Completion with buffer empty, or with `out_valid` & `out_ready` in the same cycle: load the buffer; `out_valid`=1 the next cycle.
  - Latency from the last digit to `out_valid` is 1 cycle.
  - Completion while `out_valid`=1 & !`out_ready`: the new word is dropped, `overflow` is set, and the buffered word is held unchanged.
  - `out_valid` & `out_ready` with no completion: `out_valid`=0 the next cycle; `out_data` keeps its value.
  - While `out_valid`=1 & !`out_ready`, `out_data`, `budget_err` and `fmt_err` must stay stable.
- `frame_err` and `overflow` clear only on reset.

Test Plan:
- Single word, budget=0, always ready. Stimulus: lane0 `digit_stream` 00001001 / `sign_stream` 00000001 (MSB first); lane1 00000101 / 00000100; other lanes all zero. Response: `out_valid` 1 cycle after the 8th digit; lane0=+7, lane1=-3, others 0; no error flags.
- Budget check. Stimulus: lane2 digits 10101010 (4 nonzero, all positive) with budget=1. Response: lane2=+170, `budget_err[2]`=1. Repeat with 3 nonzero digits and budget=1: `budget_err[2]`=0.
- Format and stall. Stimulus: lane3 `sign_stream`=1 with `digit_stream`=0 on digit 4, and `in_valid` deasserted for 5 cycles mid-word. Response: lane3 value unaffected by the bad digit, `fmt_err[3]`=1; `out_valid` arrives 1 cycle after the last valid digit.
- Abort. Stimulus: `in_start` on digit 5 of a word, then a full word of all +1 digits on every lane. Response: `frame_err`=1; a single output with every lane=+255.
- Backpressure. Stimulus: `out_ready`=0 across two back-to-back words. Response: the first word is held stable, the second is dropped, `overflow`=1. Then `out_ready`=1 in the same cycle as a third completion: the third word is loaded with no gap in `out_valid`.
- Async reset. Stimulus: `reset` low mid-word, asserted between clock edges. Response: all outputs go to 0 immediately; the next word decodes correctly.
